// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: CRC constants, FIFO word layout and
// transmitter state encoding.
package modbus_pkg;

  localparam logic [15:0] MODBUS_CRC_POLY = 16'hA001;
  localparam logic [15:0] MODBUS_CRC_INIT = 16'hFFFF;
  localparam int          EOF_BIT         = 8;
  localparam int          FIFO_WIDTH      = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CRC_LO,
    CRC_HI,
    DRAIN,
    GAP
  } txState_e;

endpackage

// File: rtl/modbus_crc16_step.sv
// One-byte Modbus CRC16 update (reflected 0x8005), shared with the
// receive-side CRC checker.
module modbus_crc16_step
  import modbus_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  logic [15:0] work;

  always_comb begin
    work = crc_i ^ {8'h00, byte_i};
    for (int i = 0; i < 8; i++) begin
      if (work[0]) begin
        work = (work >> 1) ^ MODBUS_CRC_POLY;
      end else begin
        work = work >> 1;
      end
    end
    crc_o = work;
  end

endmodule

// File: rtl/modbus_rtu_tx.sv
// Modbus RTU frame transmitter: FIFO bytes to UART, CRC16 appended low byte
// first, then T3.5 line silence before the next frame may start.
module modbus_rtu_tx
  import modbus_pkg::*;
#(
  parameter int SILENCE_CYCLES = 40,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifoEmpty,
  output logic                  readReq,
  input  logic                  readAck,
  input  logic [FIFO_WIDTH-1:0] dataIn,
  output logic [7:0]            txData,
  output logic                  txReq,
  input  logic                  txAck,
  input  logic                  txBusy,
  output logic                  busy,
  output logic                  frameDone
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(SILENCE_CYCLES - 1);

  txState_e             state_q;
  logic [15:0]          crc_q;
  logic [15:0]          crc_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 hasData_q;
  logic                 readReq_q;
  logic                 txReq_q;
  logic [7:0]           txData_q;
  logic                 busy_q;
  logic                 frameDone_q;

  modbus_crc16_step u_crcStep (
    .crc_i  (crc_q),
    .byte_i (dataIn[7:0]),
    .crc_o  (crc_d)
  );

  // After every UART handshake txReq is dropped for at least one cycle, so
  // CRC_HI raises its own request on its first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      crc_q       <= MODBUS_CRC_INIT;
      count_q     <= '0;
      hasData_q   <= 1'b0;
      readReq_q   <= 1'b0;
      txReq_q     <= 1'b0;
      txData_q    <= 8'h00;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          crc_q     <= MODBUS_CRC_INIT;
          hasData_q <= 1'b0;
          readReq_q <= 1'b0;
          if (!fifoEmpty) begin
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (readReq_q && readAck) begin
            readReq_q <= 1'b0;
            if (!dataIn[EOF_BIT]) begin
              txData_q  <= dataIn[7:0];
              crc_q     <= crc_d;
              hasData_q <= 1'b1;
              txReq_q   <= 1'b1;
              state_q   <= SEND;
            end else if (hasData_q) begin
              txData_q <= crc_q[7:0];
              txReq_q  <= 1'b1;
              state_q  <= CRC_LO;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            readReq_q <= !fifoEmpty;
          end
        end
        SEND: begin
          if (txReq_q && txAck) begin
            txReq_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        CRC_LO: begin
          if (txReq_q && txAck) begin
            txReq_q  <= 1'b0;
            txData_q <= crc_q[15:8];
            state_q  <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (txReq_q && txAck) begin
            txReq_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            txReq_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (!txBusy) begin
            count_q <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (txBusy) begin
            count_q <= '0;
          end else if (count_q == LAST_COUNT) begin
            frameDone_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readReq   = readReq_q;
  assign txReq     = txReq_q;
  assign txData    = txData_q;
  assign busy      = busy_q;
  assign frameDone = frameDone_q;

endmodule

// File: tb/tb_modbus_rtu_tx.sv
// Scoreboard bench for modbus_rtu_tx with behavioural FIFO and UART models.
module tb_modbus_rtu_tx;
  import modbus_pkg::*;

  localparam int SILENCE = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifoEmpty = 1'b1;
  logic       readReq;
  logic       readAck = 1'b0;
  logic [8:0] dataIn = 9'h000;
  logic [7:0] txData;
  logic       txReq;
  logic       txAck = 1'b0;
  logic       txBusy;
  logic       busy;
  logic       frameDone;
  logic       forceBusy = 1'b0;

  logic [8:0] fifoQ[$];
  logic [7:0] expQ[$];
  logic [8:0] frame1[7] = '{9'h001, 9'h003, 9'h000, 9'h000, 9'h000, 9'h001, 9'h100};

  int   checks = 0;
  int   errors = 0;
  int   seenFrames = 0;
  int   expFrames = 0;
  int   ackDelay = 1;
  int   waitCnt = 0;
  int   busyCnt = 0;
  int   cyc = 0;
  int   fallCyc = 0;
  bit   ackSeen = 0;
  bit   afterDone = 0;
  bit   prevPending = 0;
  bit   prevReq = 0;
  bit   prevBusy = 0;
  bit   sawTxReq = 0;
  logic [7:0] prevData = 8'h00;

  assign txBusy = (busyCnt != 0) || forceBusy;

  always #5 clk = ~clk;

  modbus_rtu_tx #(.SILENCE_CYCLES(SILENCE), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifoEmpty (fifoEmpty),
    .readReq   (readReq),
    .readAck   (readAck),
    .dataIn    (dataIn),
    .txData    (txData),
    .txReq     (txReq),
    .txAck     (txAck),
    .txBusy    (txBusy),
    .busy      (busy),
    .frameDone (frameDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Push frame1 words first..last into the FIFO and their expected UART bytes.
  task automatic applyStimulus(input int first, input int last, input bit withCrc);
    for (int i = first; i <= last; i++) begin
      fifoQ.push_back(frame1[i]);
      if (!frame1[i][8]) begin
        expQ.push_back(frame1[i][7:0]);
      end else if (withCrc) begin
        expQ.push_back(8'h84);
        expQ.push_back(8'h0A);
        expFrames++;
      end
    end
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (seenFrames < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (seenFrames < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL frameDoneTimeout: got %0d frames, expected %0d", seenFrames, target);
    end
  endtask

  task automatic waitExpEmpty();
    int n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL byteTimeout: got %0d bytes pending, expected 0", expQ.size());
    end
  endtask

  // FIFO and UART models drive their inputs on the falling edge.
  always @(negedge clk) begin
    fifoEmpty = (fifoQ.size() == 0);
    readAck   = readReq && !fifoEmpty;
    dataIn    = readAck ? fifoQ[0] : 9'h000;
    if (txReq && !txAck) begin
      if (waitCnt >= ackDelay) txAck = 1'b1;
      else waitCnt++;
    end else begin
      txAck   = 1'b0;
      waitCnt = 0;
    end
    if (ackSeen) busyCnt = 6;
    else if (busyCnt > 0) busyCnt--;
    ackSeen = 0;
  end

  // Monitor: pops the scoreboard on every UART handshake and checks protocol rules.
  always @(posedge clk) begin
    logic [7:0] expByte;
    cyc++;
    if (rst) begin
      if (txReq) begin
        sawTxReq = 1;
        checks++;
        if (readReq) begin
          errors++;
          $display("[TB] FAIL reqOverlap: got readReq=1 with txReq=1, expected readReq=0");
        end
      end
      if (txReq && prevPending) begin
        checks++;
        if (txData !== prevData) begin
          errors++;
          $display("[TB] FAIL txDataStable: got %0h, expected %0h", txData, prevData);
        end
      end
      if (txReq && txAck) begin
        ackSeen = 1;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedByte: got %0h, expected no byte", txData);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("txData", {24'h0, txData}, {24'h0, expByte});
        end
      end
      if (txReq && !prevReq && afterDone) begin
        checks++;
        if (cyc - fallCyc < SILENCE) begin
          errors++;
          $display("[TB] FAIL interFrameGap: got %0d cycles, expected >= %0d", cyc - fallCyc, SILENCE);
        end
        afterDone = 0;
      end
      if (frameDone) begin
        seenFrames++;
        afterDone = 1;
      end
      if (prevBusy && !txBusy) fallCyc = cyc;
    end
    if (readAck && fifoQ.size() > 0) void'(fifoQ.pop_front());
    prevPending = txReq && !txAck;
    prevReq     = txReq;
    prevData    = txData;
    prevBusy    = txBusy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetReadReq", {31'h0, readReq}, 0);
    checkOutput("resetTxReq", {31'h0, txReq}, 0);
    checkOutput("resetBusy", {31'h0, busy}, 0);
    checkOutput("resetFrameDone", {31'h0, frameDone}, 0);
    checkOutput("resetTxData", {24'h0, txData}, 0);
    rst = 1'b1;

    $display("[TB] test 1: basic frame");
    ackDelay = 1;
    applyStimulus(0, 6, 1);
    waitFrames(1);

    $display("[TB] test 2: empty frame");
    sawTxReq = 0;
    applyStimulus(6, 6, 0);
    repeat (30) @(negedge clk);
    checkOutput("emptyNoTxReq", {31'h0, sawTxReq}, 0);
    checkOutput("emptyBusy", {31'h0, busy}, 0);
    checkOutput("emptyNoFrameDone", seenFrames, 1);
    checkOutput("emptyFifoDrained", fifoQ.size(), 0);

    $display("[TB] test 3: back-to-back frames");
    applyStimulus(0, 6, 1);
    applyStimulus(0, 6, 1);
    waitFrames(3);

    $display("[TB] test 4: FIFO stall and slow UART");
    ackDelay = 5;
    applyStimulus(0, 2, 1);
    waitExpEmpty();
    repeat (20) @(negedge clk);
    checkOutput("stallBusy", {31'h0, busy}, 1);
    checkOutput("stallTxReq", {31'h0, txReq}, 0);
    checkOutput("stallNoFrameDone", seenFrames, 3);
    applyStimulus(3, 6, 1);
    waitFrames(4);

    $display("[TB] test 5: reset during CRC_LO");
    applyStimulus(0, 6, 1);
    n = 0;
    while (!(expQ.size() == 2 && txReq) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachCrcLo", {31'h0, txReq}, 1);
    rst = 1'b0;
    #1;
    checkOutput("midResetTxReq", {31'h0, txReq}, 0);
    checkOutput("midResetReadReq", {31'h0, readReq}, 0);
    checkOutput("midResetBusy", {31'h0, busy}, 0);
    checkOutput("midResetTxData", {24'h0, txData}, 0);
    expFrames--;
    expQ.delete();
    fifoQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ackDelay = 1;
    applyStimulus(0, 6, 1);
    waitFrames(5);

    $display("[TB] test 6: txBusy re-asserted during silence");
    applyStimulus(0, 6, 1);
    waitExpEmpty();
    repeat (2) @(negedge clk);
    n = 0;
    while (txBusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (11) @(negedge clk);
    forceBusy = 1'b1;
    repeat (4) @(negedge clk);
    forceBusy = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (frameDone) break;
    end
    checkOutput("gapRestart", n, SILENCE);
    repeat (5) @(negedge clk);

    checkOutput("frameCount", seenFrames, expFrames);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
